// File: rtl/periph_pkg.sv
// -----------------------------------------------------------------------------
// periph_pkg
// Shared constants for the memory-mapped peripheral block:
//   - default base address of the 32-byte peripheral window
//   - register byte offsets and the matching word indices (offset[4:2])
//   - TCON bit positions
// Optional feature macro used by the block: PERIPH_SYSTICK_EN.
// -----------------------------------------------------------------------------
package periph_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets inside the window
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LEDS    = 5'h0C;
  localparam logic [4:0] OFF_DIGITS  = 5'h10;
  localparam logic [4:0] OFF_SYSTICK = 5'h14;

  // Word indices used by the decoder (byte lane bits [1:0] are ignored)
  localparam logic [2:0] IDX_TH      = OFF_TH[4:2];
  localparam logic [2:0] IDX_TL      = OFF_TL[4:2];
  localparam logic [2:0] IDX_TCON    = OFF_TCON[4:2];
  localparam logic [2:0] IDX_LEDS    = OFF_LEDS[4:2];
  localparam logic [2:0] IDX_DIGITS  = OFF_DIGITS[4:2];
  localparam logic [2:0] IDX_SYSTICK = OFF_SYSTICK[4:2];

  // TCON bit positions
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/periph_timer.sv
// -----------------------------------------------------------------------------
// periph_timer
// Programmable reload timer: TH (reload value), TL (counter), TCON (control).
// When enabled TL counts up each cycle; on TL == all-ones it reloads from TH
// and, if interrupts are enabled, latches the sticky interrupt status bit.
//
// Ports:
//   clk        input   system clock
//   reset      input   asynchronous active-high reset
//   i_we_th    input   CPU write strobe for TH
//   i_we_tl    input   CPU write strobe for TL
//   i_we_tcon  input   CPU write strobe for TCON
//   i_wdata    input   [31:0] CPU store data
//   o_th       output  [31:0] TH register
//   o_tl       output  [31:0] TL register
//   o_tcon     output  [2:0]  TCON register (IS, IE, EN)
//   o_irq      output  interrupt request (TCON status bit)
// -----------------------------------------------------------------------------
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_th,
  input  logic        i_we_tl,
  input  logic        i_we_tcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic        w_run;
  logic        w_wrap;
  logic        w_set_is;
  logic [31:0] w_tl_next;

  assign w_run    = r_tcon[TCON_EN];
  assign w_wrap   = w_run && (r_tl == 32'hFFFF_FFFF);
  assign w_set_is = w_wrap && r_tcon[TCON_IE];

  // Free-running next value of TL: reload from the current (old) TH on wrap
  always_comb begin
    w_tl_next = r_tl;
    if (w_wrap) begin
      w_tl_next = r_th;
    end else if (w_run) begin
      w_tl_next = r_tl + 32'd1;
    end else begin
      w_tl_next = r_tl;
    end
  end

  // Timer registers; CPU writes override counting, but an overflow set of the
  // status bit is merged into a same-cycle TCON write so it is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= 32'd0;
      r_tl   <= 32'd0;
      r_tcon <= 3'd0;
    end else begin
      if (i_we_th) begin
        r_th <= i_wdata;
      end

      if (i_we_tl) begin
        r_tl <= i_wdata;
      end else begin
        r_tl <= w_tl_next;
      end

      if (i_we_tcon) begin
        r_tcon <= {i_wdata[TCON_IS] | w_set_is, i_wdata[TCON_IE], i_wdata[TCON_EN]};
      end else if (w_set_is) begin
        r_tcon[TCON_IS] <= 1'b1;
      end
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// -----------------------------------------------------------------------------
// periph_bus
// Memory-mapped peripheral block on the CPU data bus. Decodes a 32-byte
// window at BASE_ADDR, returns read data combinationally and commits writes
// on the rising clock edge.
//   0x00 TH, 0x04 TL, 0x08 TCON (timer, in periph_timer)
//   0x0C LEDS [7:0], 0x10 DIGITS [11:0], 0x14 SYSTICK (read-only)
//   0x18, 0x1C reserved (read 0, writes ignored)
//
// Optional feature: define PERIPH_SYSTICK_EN to build the free-running
// SYSTICK counter; otherwise offset 0x14 reads 0 and no counter exists.
//
// Parameters:
//   BASE_ADDR          window base, must be 32-byte aligned
// Ports:
//   clk                input   system clock
//   reset              input   asynchronous active-high reset
//   MemRead            input   bus read strobe
//   MemWrite           input   bus write strobe
//   MemBus_Address     input   [31:0] byte address
//   MemBus_Write_Data  input   [31:0] store data
//   Device_Read_Data   output  [31:0] read data (0 when not reading this window)
//   irq                output  timer interrupt request (TCON[2])
//   leds               output  [7:0]  LED register
//   digits             output  [11:0] seven-segment drive (anodes, segments)
// -----------------------------------------------------------------------------
module periph_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  logic        w_hit;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_we_th;
  logic        w_we_tl;
  logic        w_we_tcon;
  logic [31:0] w_th;
  logic [31:0] w_tl;
  logic [2:0]  w_tcon;
  logic [31:0] w_systick;
  logic [31:0] w_rd_sel;
  logic        w_unused_addr;

  logic [7:0]  r_leds;
  logic [11:0] r_digits;

  // Byte-lane bits carry no meaning for word registers
  assign w_unused_addr = ^MemBus_Address[1:0];

  assign w_hit     = (MemBus_Address[31:5] == BASE_ADDR[31:5]);
  assign w_idx     = MemBus_Address[4:2];
  assign w_wr      = MemWrite && w_hit;
  assign w_we_th   = w_wr && (w_idx == IDX_TH);
  assign w_we_tl   = w_wr && (w_idx == IDX_TL);
  assign w_we_tcon = w_wr && (w_idx == IDX_TCON);

  periph_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_we_th   (w_we_th),
    .i_we_tl   (w_we_tl),
    .i_we_tcon (w_we_tcon),
    .i_wdata   (MemBus_Write_Data),
    .o_th      (w_th),
    .o_tl      (w_tl),
    .o_tcon    (w_tcon),
    .o_irq     (irq)
  );

  // LED and seven-segment registers keep only their implemented bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_leds   <= 8'd0;
      r_digits <= 12'd0;
    end else begin
      if (w_wr && (w_idx == IDX_LEDS)) begin
        r_leds <= MemBus_Write_Data[7:0];
      end
      if (w_wr && (w_idx == IDX_DIGITS)) begin
        r_digits <= MemBus_Write_Data[11:0];
      end
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] r_systick;

  // Free-running cycle counter, wraps naturally; CPU writes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_systick <= 32'd0;
    end else begin
      r_systick <= r_systick + 32'd1;
    end
  end

  assign w_systick = r_systick;
`else
  assign w_systick = 32'd0;
`endif

  // Register select, zero-extended; reserved slots return 0
  always_comb begin
    w_rd_sel = 32'd0;
    case (w_idx)
      IDX_TH:      w_rd_sel = w_th;
      IDX_TL:      w_rd_sel = w_tl;
      IDX_TCON:    w_rd_sel = {29'd0, w_tcon};
      IDX_LEDS:    w_rd_sel = {24'd0, r_leds};
      IDX_DIGITS:  w_rd_sel = {20'd0, r_digits};
      IDX_SYSTICK: w_rd_sel = w_systick;
      default:     w_rd_sel = 32'd0;
    endcase
  end

  // Drive the shared read bus only for our own window so it can be OR'd
  // with other devices' read data
  assign Device_Read_Data = (MemRead && w_hit) ? w_rd_sel : 32'd0;
  assign leds             = r_leds;
  assign digits           = r_digits;

endmodule

// File: tb/tb_periph_bus.sv
// -----------------------------------------------------------------------------
// tb_periph_bus
// Randomized and directed stimulus for periph_bus with a behavioural
// reference model. Each bus cycle pushes the expected read data and output
// values into a scoreboard queue; a monitor on the falling clock edge pops
// and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_periph_bus;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  periph_bus #(.BASE_ADDR(BASE)) dut (
    .clk               (clk),
    .reset             (reset),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .MemBus_Address    (MemBus_Address),
    .MemBus_Write_Data (MemBus_Write_Data),
    .Device_Read_Data  (Device_Read_Data),
    .irq               (irq),
    .leds              (leds),
    .digits            (digits)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_leds;
  logic [11:0] m_digits;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digits;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int tag_ctr = 0;

  task automatic model_reset();
    m_th = 32'd0; m_tl = 32'd0; m_tcon = 3'd0;
    m_leds = 8'd0; m_digits = 12'd0; m_systick = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_tcon};
      3'd3: return {24'd0, m_leds};
      3'd4: return {20'd0, m_digits};
`ifdef PERIPH_SYSTICK_EN
      3'd5: return m_systick;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the block: timer rule first, then the CPU write wins
  task automatic model_clock(input logic mw, input logic [31:0] a, input logic [31:0] wd);
    logic        fired;
    logic [31:0] tl_n, th_n;
    logic [2:0]  tcon_n;
    fired = 1'b0; tl_n = m_tl; th_n = m_th; tcon_n = m_tcon;
    if (m_tcon[0]) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        tl_n  = m_th;
        fired = m_tcon[1];
      end else begin
        tl_n = m_tl + 32'd1;
      end
    end
    if (fired) tcon_n[2] = 1'b1;
    if (mw && (a[31:5] == BASE[31:5])) begin
      case (a[4:2])
        3'd0: th_n = wd;
        3'd1: tl_n = wd;
        3'd2: tcon_n = wd[2:0] | {fired, 2'b00};
        3'd3: m_leds = wd[7:0];
        3'd4: m_digits = wd[11:0];
        default: ;
      endcase
    end
    m_th = th_n; m_tl = tl_n; m_tcon = tcon_n;
    m_systick = m_systick + 32'd1;
  endtask

  // One bus cycle: drive, record expectation, clock the model with the DUT
  task automatic cycle(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    MemRead = mr; MemWrite = mw; MemBus_Address = a; MemBus_Write_Data = wd;
    e.rd = mr ? model_read(a) : 32'd0;
    e.irq = m_tcon[2]; e.leds = m_leds; e.digits = m_digits; e.tag = tag_ctr;
    tag_ctr++;
    sb.push_back(e);
    @(posedge clk);
    model_clock(mw, a, wd);
    #1;
  endtask

  task automatic rd(input logic [31:0] off);
    cycle(1'b1, 1'b0, BASE + off, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b0, 1'b1, BASE + off, d);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int tag);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("rdata",  Device_Read_Data,   e.rd,                 e.tag);
        check("irq",    {31'd0, irq},       {31'd0, e.irq},       e.tag);
        check("leds",   {24'd0, leds},      {24'd0, e.leds},      e.tag);
        check("digits", {20'd0, digits},    {20'd0, e.digits},    e.tag);
      end
    end
  end

  initial begin
    int guard;
    exp_t e;
    logic [31:0] a, wd;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    MemBus_Address = 32'd0; MemBus_Write_Data = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: every offset, a non-read, and a miss
    for (int i = 0; i < 8; i++) rd(32'(i * 4));
    cycle(1'b0, 1'b0, BASE + 32'h4, 32'd0);
    cycle(1'b1, 1'b0, BASE + 32'h20, 32'd0);

    // LEDS / DIGITS
    wr(32'h0C, 32'h0000_00A5);
    wr(32'h10, 32'h0FFF_FF3C);
    rd(32'h0C);
    rd(32'h10);

    // Ignored writes: misses, reserved, SYSTICK
    cycle(1'b0, 1'b1, 32'h3FFF_FFFC, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b1, BASE + 32'h20, 32'h1234_5678);
    wr(32'h18, 32'hCAFE_F00D);
    wr(32'h14, 32'h5555_5555);
    for (int i = 0; i < 8; i++) rd(32'(i * 4));

    // SYSTICK read twice, 5 cycles apart
    rd(32'h14);
    repeat (4) cycle(1'b0, 1'b0, BASE, 32'd0);
    rd(32'h14);

    // Timer reload and interrupt
    wr(32'h00, 32'hFFFF_FFF0);
    wr(32'h04, 32'hFFFF_FFF0);
    wr(32'h08, 32'd3);
    repeat (20) rd(32'h04);
    rd(32'h08);
    wr(32'h08, 32'd3);
    rd(32'h08);

    // TCON write in the exact overflow cycle keeps the interrupt
    guard = 0;
    while (m_tl != 32'hFFFF_FFFF && guard < 40) begin rd(32'h04); guard++; end
    wr(32'h08, 32'd3);
    rd(32'h08);
    rd(32'h04);

    // TH write in the reload cycle: TL takes the old TH
    guard = 0;
    while (m_tl != 32'hFFFF_FFFF && guard < 40) begin rd(32'h04); guard++; end
    wr(32'h00, 32'h1234_5678);
    rd(32'h04);
    rd(32'h00);
    // TL write while counting
    wr(32'h04, 32'h0000_0100);
    rd(32'h04);
    rd(32'h08);

    // Asynchronous reset mid-count with irq=1; checked before any edge
    #1 reset = 1'b1;
    model_reset();
    MemRead = 1'b1; MemWrite = 1'b0; MemBus_Address = BASE + 32'h4;
    e.rd = 32'd0; e.irq = 1'b0; e.leds = 8'd0; e.digits = 12'd0; e.tag = tag_ctr;
    tag_ctr++;
    sb.push_back(e);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) rd(32'(i * 4));

    // Randomized traffic, biased so the counter wraps often
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = BASE | {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else wd = $urandom();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd);
    end

    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
